seq_divider: RTL
================

Name: seq_divider

Overview:
- Parametrised, multi-cycle restoring unsigned divider with a start/done handshake.
- Successor to the team's fixed 4-bit combinational divider. It replaces a WIDTH²-deep comparator/subtractor chain with one shared compare-subtract step per clock.
- Adds divide-by-zero detection, a busy indication and registered, held results.
- Sits as a co-processor beside the lab ALU; the controller issues start and waits for done.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- numerator  input  WIDTH  dividend; captured on the accepted start edge.
- denominator  input  WIDTH  divisor; captured on the accepted start edge.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse, high while in DONE.
- quotient  output  WIDTH  registered quotient; held until the next accepted start.
- remainder  output  WIDTH  registered remainder; held until the next accepted start.
- div_by_zero  output  1  registered flag for the last operation; held like the results.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, internal counter and registers all 0.
- Reset mid-operation: aborts immediately; all outputs take their reset values.
- States: IDLE, CALC, DONE (enum in the package).
- IDLE, start=1, denominator!=0:
  - Capture operands.
  - Working remainder R (WIDTH+1 bits) = 0; working quotient Q = numerator.
  - Counter = WIDTH-1; go to CALC.
  - Clear div_by_zero.
- IDLE, start=1, denominator==0:
  - Go straight to DONE.
  - quotient = all ones; remainder = numerator; div_by_zero = 1.
- IDLE, start=0: stay in IDLE.
- CALC, one step per cycle (restoring division):
  - T = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - If T >= {1'b0, D}: R = T - D, new Q LSB = 1.
  - Otherwise: R = T, new Q LSB = 0.
  - Q shifts left by one each step.
  - Counter decrements. When counter==0, load quotient=Q and remainder=R[WIDTH-1:0], then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Latency, counted from the edge that accepts start to the edge that enters DONE:
  - WIDTH edges for a normal operation.
  - 1 edge for divide-by-zero.
  - done is visible during the following cycle.
- Minimum issue interval: WIDTH+2 cycles.
- start is ignored in CALC and DONE; there is no queuing.
- A start held high re-triggers on the first IDLE cycle.
- Operands may change freely after the accepted edge.
- Arithmetic: all unsigned. The remainder is always < denominator when denominator != 0. quotient*denominator + remainder == numerator exactly.

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- Defined: in IDLE, an accepted start with denominator!=0 and numerator<denominator skips CALC and goes directly to DONE, with quotient=0 and remainder=numerator. Latency is 1 edge; div_by_zero=0.
- Not defined: all nonzero-divisor operations take the full WIDTH-edge CALC path. Results are identical either way; only timing differs.

Decomposition:
- Package div_pkg:
  - typedef enum logic [1:0] div_state_t {IDLE, CALC, DONE}.
  - Function clog2-based counter width helper for the counter register, sized $clog2(WIDTH).
- Sub-module div_step, combinational, parametrised by WIDTH:
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: next remainder and quotient bit.
- seq_divider instantiates one div_step and owns the FSM, counter and registers.

Test Plan:
- WIDTH=4, 13/3 -> after 4 edges done=1 for one cycle, quotient=4, remainder=1, div_by_zero=0; busy high for 5 cycles.
- WIDTH=4, 7/0 -> done one edge after start; quotient=15, remainder=7, div_by_zero=1. The next op 9/2 gives q=4, r=1 and clears div_by_zero.
- WIDTH=4, 15/1 -> q=15, r=0. Then 0/5 -> q=0, r=0. With DIV_EARLY_EXIT_EN, 2/9 gives done after 1 edge with q=0, r=2; without the macro it takes 4 edges with the same result.
- Start 12/5, then pulse start with 3/1 during CALC -> second request ignored; result q=2, r=2; outputs hold after done until the next start.
- Assert rst_n=0 asynchronously mid-CALC of 14/3 -> all outputs 0 immediately without a clock edge. Release, then run 14/3 -> q=4, r=2.
- WIDTH=8, 255/16 -> q=15, r=15 after 8 edges. Random sweep of 1000 operand pairs -> q*d+r==n and r<d for every d!=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential divider.
// Provides the FSM state enum and the step-counter width helper.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Counter must hold WIDTH-1; never narrower than one bit.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract.
// Ports: rem_i/bit_i/div_i in; rem_o (next remainder), q_o (quotient bit).
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] t;
  logic           ge;

  always_comb begin
    t  = {rem_i, bit_i};
    ge = (t >= {1'b0, div_i});
    q_o = ge;
    // After a successful subtract the result is < divisor, so it fits WIDTH bits.
    rem_o = ge ? WIDTH'(t - {1'b0, div_i}) : t[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring unsigned divider with start/done handshake.
// Ports: clk, rst_n, start, numerator, denominator -> busy, done,
// quotient, remainder, div_by_zero. Option: DIV_EARLY_EXIT_EN.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] numerator,
  input  logic [WIDTH-1:0] denominator,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_w(WIDTH);

  div_state_t     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  // Working remainder stays below the divisor, so WIDTH bits suffice.
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] den_q, den_d;
  logic [WIDTH-1:0] qout_q, qout_d;
  logic [WIDTH-1:0] rout_q, rout_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .bit_i (quo_q[WIDTH-1]),
    .div_i (den_q),
    .rem_o (step_rem),
    .q_o   (step_bit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    den_d   = den_q;
    qout_d  = qout_q;
    rout_d  = rout_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (denominator == '0) begin
            state_d = DONE;
            qout_d  = '1;
            rout_d  = numerator;
            dbz_d   = 1'b1;
          end
`ifdef DIV_EARLY_EXIT_EN
          else if (numerator < denominator) begin
            state_d = DONE;
            qout_d  = '0;
            rout_d  = numerator;
            dbz_d   = 1'b0;
          end
`endif
          else begin
            state_d = CALC;
            rem_d   = '0;
            quo_d   = numerator;
            den_d   = denominator;
            cnt_d   = CW'(WIDTH - 1);
            dbz_d   = 1'b0;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_bit};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
          qout_d  = {quo_q[WIDTH-2:0], step_bit};
          rout_d  = step_rem;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      den_q   <= '0;
      qout_q  <= '0;
      rout_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      den_q   <= den_d;
      qout_q  <= qout_d;
      rout_q  <= rout_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = qout_q;
  assign remainder   = rout_q;
  assign div_by_zero = dbz_q;

endmodule
